// File: rtl/ps2_square_mover.sv
// ps2_square_mover: decodes PS/2 set-2 direction keys and steps a square once per frame.
// Latency: keys_held 1 clk after a byte edge; sq_x/sq_y/move_tick 1 clk after a screen_end edge.
// Backpressure: none; every read_data rising edge is consumed, SQUARE_WRAP_EN selects wrap vs clamp.
module ps2_square_mover #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int SQ_SIZE  = 32,
  parameter int STEP     = 2,
  parameter int X_INIT   = 304,
  parameter int Y_INIT   = 224
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       read_data,
  input  logic [7:0] rx_data,
  input  logic       screen_end,
  output logic [9:0] sq_x,
  output logic [8:0] sq_y,
  output logic [3:0] keys_held,
  output logic       move_tick
);

  localparam logic [10:0] X_MAX  = 11'(SCREEN_W - SQ_SIZE);
  localparam logic [10:0] Y_MAX  = 11'(SCREEN_H - SQ_SIZE);
  localparam logic [10:0] STEP_W = 11'(STEP);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} parse_t;

  parse_t      state_q, state_d;
  logic        read_data_q, screen_end_q;
  logic [3:0]  keys_q, keys_d;
  logic [9:0]  sq_x_q, sq_x_d;
  logic [8:0]  sq_y_q, sq_y_d;
  logic        move_tick_q, move_tick_d;

  logic        byte_acc, frame_edge;
  logic        key_we, key_set, key_ext;
  logic [3:0]  key_mask;
  logic [10:0] x_ext, y_ext, x_sum, x_dif, y_sum, y_dif, x_nxt, y_nxt;

  assign byte_acc   = read_data & ~read_data_q;
  assign frame_edge = screen_end & ~screen_end_q;

  // Parser next state and key flag update; a key event is resolved in the byte's accept cycle.
  always_comb begin
    state_d  = state_q;
    key_we   = 1'b0;
    key_set  = 1'b0;
    key_ext  = 1'b0;
    key_mask = 4'b0000;
    keys_d   = keys_q;
    if (byte_acc) begin
      unique case (state_q)
        IDLE: begin
          if (rx_data == 8'hE0)      state_d = EXT;
          else if (rx_data == 8'hF0) state_d = BRK;
          else begin
            key_we  = 1'b1;
            key_set = 1'b1;
          end
        end
        EXT: begin
          if (rx_data == 8'hF0)      state_d = EXT_BRK;
          else if (rx_data != 8'hE0) begin
            key_we  = 1'b1;
            key_set = 1'b1;
            key_ext = 1'b1;
            state_d = IDLE;
          end
        end
        BRK: begin
          key_we  = 1'b1;
          state_d = IDLE;
        end
        EXT_BRK: begin
          key_we  = 1'b1;
          key_ext = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    // Flag bits are {up,down,left,right}; unknown codes leave the mask empty.
    if (key_ext) begin
      case (rx_data)
        8'h75:   key_mask = 4'b1000;
        8'h72:   key_mask = 4'b0100;
        8'h6B:   key_mask = 4'b0010;
        8'h74:   key_mask = 4'b0001;
        default: key_mask = 4'b0000;
      endcase
    end else begin
      case (rx_data)
        8'h1D:   key_mask = 4'b1000;
        8'h1B:   key_mask = 4'b0100;
        8'h1C:   key_mask = 4'b0010;
        8'h23:   key_mask = 4'b0001;
        default: key_mask = 4'b0000;
      endcase
    end
    if (key_we) keys_d = key_set ? (keys_q | key_mask) : (keys_q & ~key_mask);
  end

  // Frame step: 11-bit arithmetic so a left/up step below zero shows up in bit 10.
  always_comb begin
    x_ext = {1'b0, sq_x_q};
    y_ext = {2'b00, sq_y_q};
    x_sum = x_ext + STEP_W;
    x_dif = x_ext - STEP_W;
    y_sum = y_ext + STEP_W;
    y_dif = y_ext - STEP_W;
    x_nxt = x_ext;
    y_nxt = y_ext;
    if (keys_q[0] && !keys_q[1]) begin
`ifdef SQUARE_WRAP_EN
      x_nxt = (x_sum > X_MAX) ? 11'd0 : x_sum;
`else
      x_nxt = (x_sum > X_MAX) ? X_MAX : x_sum;
`endif
    end else if (keys_q[1] && !keys_q[0]) begin
`ifdef SQUARE_WRAP_EN
      x_nxt = x_dif[10] ? X_MAX : x_dif;
`else
      x_nxt = x_dif[10] ? 11'd0 : x_dif;
`endif
    end
    if (keys_q[2] && !keys_q[3]) begin
`ifdef SQUARE_WRAP_EN
      y_nxt = (y_sum > Y_MAX) ? 11'd0 : y_sum;
`else
      y_nxt = (y_sum > Y_MAX) ? Y_MAX : y_sum;
`endif
    end else if (keys_q[3] && !keys_q[2]) begin
`ifdef SQUARE_WRAP_EN
      y_nxt = y_dif[10] ? Y_MAX : y_dif;
`else
      y_nxt = y_dif[10] ? 11'd0 : y_dif;
`endif
    end
    sq_x_d      = frame_edge ? x_nxt[9:0] : sq_x_q;
    sq_y_d      = frame_edge ? y_nxt[8:0] : sq_y_q;
    move_tick_d = frame_edge && ((x_nxt != x_ext) || (y_nxt != y_ext));
  end

  // State registers with synchronous reset; the step reads keys_q before this edge's byte lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      read_data_q  <= 1'b0;
      screen_end_q <= 1'b0;
      keys_q       <= 4'b0000;
      sq_x_q       <= 10'(X_INIT);
      sq_y_q       <= 9'(Y_INIT);
      move_tick_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      read_data_q  <= read_data;
      screen_end_q <= screen_end;
      keys_q       <= keys_d;
      sq_x_q       <= sq_x_d;
      sq_y_q       <= sq_y_d;
      move_tick_q  <= move_tick_d;
    end
  end

  assign sq_x      = sq_x_q;
  assign sq_y      = sq_y_q;
  assign keys_held = keys_q;
  assign move_tick = move_tick_q;

endmodule

// File: tb/tb_ps2_square_mover.sv
// Bench for ps2_square_mover: directed scenarios with literal expectations, then random traffic.
// Outputs are checked every cycle at negedge against a cycle-level behavioural model.
// Build with SQUARE_WRAP_EN defined to check the wrapping variant.
module tb_ps2_square_mover;

  logic       clk = 1'b0;
  logic       reset, read_data, screen_end;
  logic [7:0] rx_data;
  logic [9:0] sq_x;
  logic [8:0] sq_y;
  logic [3:0] keys_held;
  logic       move_tick;

  always #5 clk = ~clk;

  ps2_square_mover dut (
    .clk(clk), .reset(reset), .read_data(read_data), .rx_data(rx_data),
    .screen_end(screen_end), .sq_x(sq_x), .sq_y(sq_y),
    .keys_held(keys_held), .move_tick(move_tick)
  );

`ifdef SQUARE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam int XMAX = 640 - 32;
  localparam int YMAX = 480 - 32;

  int n_cmp = 0;
  int n_bad = 0;
  int tick_count = 0;

  // Behavioural model state.
  int       m_x, m_y;
  bit [3:0] m_keys;
  bit       m_tick, m_ext, m_brk, m_rd_prev, m_se_prev;
  bit       m_valid = 1'b0;

  function automatic bit [3:0] code_mask(bit ext, logic [7:0] b);
    if (!ext && b == 8'h1D) return 4'b1000;
    if (!ext && b == 8'h1B) return 4'b0100;
    if (!ext && b == 8'h1C) return 4'b0010;
    if (!ext && b == 8'h23) return 4'b0001;
    if ( ext && b == 8'h75) return 4'b1000;
    if ( ext && b == 8'h72) return 4'b0100;
    if ( ext && b == 8'h6B) return 4'b0010;
    if ( ext && b == 8'h74) return 4'b0001;
    return 4'b0000;
  endfunction

  function automatic int axis_step(int pos, int lim, bit plus, bit minus);
    int n;
    n = pos + (plus ? 2 : 0) - (minus ? 2 : 0);
    if (n < 0)        n = WRAP ? lim : 0;
    else if (n > lim) n = WRAP ? 0 : lim;
    return n;
  endfunction

  // Model advances on each rising clock using the inputs held since the previous negedge.
  always @(posedge clk) begin
    bit bn, fn;
    int nx, ny;
    if (reset) begin
      m_x = 304; m_y = 224; m_keys = 4'b0; m_tick = 1'b0;
      m_ext = 1'b0; m_brk = 1'b0; m_rd_prev = 1'b0; m_se_prev = 1'b0;
      m_valid = 1'b1;
    end else begin
      bn = read_data && !m_rd_prev;
      fn = screen_end && !m_se_prev;
      m_tick = 1'b0;
      if (fn) begin
        nx = axis_step(m_x, XMAX, m_keys[0], m_keys[1]);
        ny = axis_step(m_y, YMAX, m_keys[2], m_keys[3]);
        m_tick = (nx != m_x) || (ny != m_y);
        m_x = nx; m_y = ny;
      end
      if (bn) begin
        if (m_brk) begin
          m_keys = m_keys & ~code_mask(m_ext, rx_data);
          m_brk = 1'b0; m_ext = 1'b0;
        end else if (rx_data == 8'hF0) m_brk = 1'b1;
        else if (rx_data == 8'hE0)    m_ext = 1'b1;
        else begin
          m_keys = m_keys | code_mask(m_ext, rx_data);
          m_ext = 1'b0;
        end
      end
      m_rd_prev = read_data;
      m_se_prev = screen_end;
    end
  end

  // Cycle compare against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      n_cmp++;
      if (int'(sq_x) != m_x || int'(sq_y) != m_y || keys_held != m_keys || move_tick != m_tick) begin
        n_bad++;
        $display("FAIL cycle_check t=%0t dut x=%0d y=%0d keys=%b tick=%b required x=%0d y=%0d keys=%b tick=%b",
                 $time, sq_x, sq_y, keys_held, move_tick, m_x, m_y, m_keys, m_tick);
      end
      if (move_tick) tick_count++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; read_data = 1'b1;
    repeat (2) @(negedge clk);
    read_data = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic frame(input int hi);
    screen_end = 1'b1;
    repeat (hi) @(negedge clk);
    screen_end = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [7:0] pick_code();
    logic [7:0] tbl [10];
    tbl = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0};
    if ($urandom_range(0, 11) < 10) return tbl[$urandom_range(0, 9)];
    return 8'($urandom_range(0, 255));
  endfunction

  int xs;

  initial begin
    reset = 1'b1; read_data = 1'b0; screen_end = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_x", int'(sq_x), 304);
    check("reset_y", int'(sq_y), 224);
    check("reset_keys", int'(keys_held), 0);
    check("reset_tick", int'(move_tick), 0);
    reset = 1'b0;
    @(negedge clk);

    tick_count = 0;
    repeat (3) frame(1);
    check("idle_x", int'(sq_x), 304);
    check("idle_y", int'(sq_y), 224);
    check("idle_ticks", tick_count, 0);

    send_byte(8'h23);
    check("d_make_keys", int'(keys_held), 1);
    repeat (2) frame(1);
    check("d_move_x", int'(sq_x), 308);
    send_byte(8'hF0); send_byte(8'h23);
    check("d_break_keys", int'(keys_held), 0);
    frame(1);
    check("d_released_x", int'(sq_x), 308);

    send_byte(8'hE0); send_byte(8'h75);
    check("up_make_keys", int'(keys_held), 8);
    frame(1);
    check("up_move_y", int'(sq_y), 222);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check("up_break_keys", int'(keys_held), 0);

    do_reset();
    send_byte(8'h1C);
    tick_count = 0;
    repeat (152) frame(1);
    check("left_edge_x", int'(sq_x), 0);
    check("left_edge_ticks", tick_count, 152);
    frame(1);
    check("left_153_x", int'(sq_x), WRAP ? 608 : 0);
    check("left_153_ticks", tick_count, WRAP ? 153 : 152);
    repeat (47) frame(1);
    xs = WRAP ? 514 : 0;
    check("left_200_x", int'(sq_x), xs);
    check("left_200_ticks", tick_count, WRAP ? 200 : 152);

    send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'h1C); send_byte(8'h23);
    check("both_keys", int'(keys_held), 3);
    tick_count = 0;
    frame(1);
    check("both_x", int'(sq_x), xs);
    check("both_ticks", tick_count, 0);
    send_byte(8'hF0); send_byte(8'h1C);
    frame(4);
    check("long_frame_x", int'(sq_x), xs + 2);
    check("long_frame_ticks", tick_count, 1);

    send_byte(8'hF0); send_byte(8'h23);
    rx_data = 8'h23; read_data = 1'b1; screen_end = 1'b1;
    @(negedge clk);
    screen_end = 1'b0;
    repeat (2) @(negedge clk);
    read_data = 1'b0;
    repeat (2) @(negedge clk);
    check("same_cycle_x", int'(sq_x), xs + 2);
    check("same_cycle_keys", int'(keys_held), 1);
    frame(1);
    check("same_cycle_next_x", int'(sq_x), xs + 4);

    send_byte(8'hE0);
    do_reset();
    send_byte(8'h23);
    check("prefix_drop_keys", int'(keys_held), 1);
    send_byte(8'h75);
    check("prefix_drop_75", int'(keys_held), 1);

    for (int i = 0; i < 5000; i++) begin
      reset = ($urandom_range(0, 599) == 0);
      if (!read_data && $urandom_range(0, 3) == 0) begin
        rx_data = pick_code();
        read_data = 1'b1;
      end else if (read_data && $urandom_range(0, 2) == 0) begin
        read_data = 1'b0;
      end
      if ($urandom_range(0, 4) == 0) screen_end = ~screen_end;
      @(negedge clk);
    end
    reset = 1'b0; read_data = 1'b0; screen_end = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
